// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encoding and pipeline control vectors for pipeline_stall_ctrl
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic pc_sel_br;
        logic p0_we;
        logic p0_flush;
        logic p1_bubble;
    } ctrl_t;

    // Bit order: {pc_we, pc_sel_br, p0_we, p0_flush, p1_bubble}
    localparam ctrl_t CTRL_IDLE     = ctrl_t'(5'b10100);
    localparam ctrl_t CTRL_STALL    = ctrl_t'(5'b00001);
    localparam ctrl_t CTRL_REDIRECT = ctrl_t'(5'b11110);
    localparam ctrl_t CTRL_SQUASH   = ctrl_t'(5'b10110);
    localparam ctrl_t CTRL_HLT      = ctrl_t'(5'b00110);
    localparam ctrl_t CTRL_DRAIN    = ctrl_t'(5'b00111);
    // Frozen front end with NOPs in both registers; used for reset and HALT.
    localparam ctrl_t CTRL_BUBBLE   = ctrl_t'(5'b00011);

    localparam int SCNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush/halt sequencer for the 5-stage pipeline
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             hazard_flush,
    input  logic             p1_hlt,
    output logic             pc_we,
    output logic             pc_sel_br,
    output logic             p0_we,
    output logic             p0_flush,
    output logic             p1_bubble,
    output logic             halted,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        timeout_q, timeout_d;
    ctrl_t       ctrl;
    logic        run_stall;
    logic        timeout_set;
    logic [SCNT_W-1:0] scnt;

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        dcnt_d    = dcnt_q;
        ctrl      = CTRL_IDLE;
        run_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A stalled branch waits for its operand, so stall outranks flush.
                if (hazard_stall) begin
                    ctrl      = CTRL_STALL;
                    run_stall = 1'b1;
                end else if (hazard_flush) begin
                    ctrl = CTRL_REDIRECT;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = 3'(FLUSH_CYCLES - 1);
                    end
                end else if (p1_hlt) begin
                    ctrl = CTRL_HLT;
                    if (DRAIN_CYCLES > 1) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = 3'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_FLUSH: begin
                ctrl   = CTRL_SQUASH;
                fcnt_d = fcnt_q - 3'd1;
                if (fcnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ctrl   = CTRL_DRAIN;
                dcnt_d = dcnt_q - 3'd1;
                if (dcnt_q == 3'd1) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                ctrl = CTRL_BUBBLE;
            end
        endcase
        if (rst) begin
            ctrl      = CTRL_BUBBLE;
            run_stall = 1'b0;
        end
    end

    sat_counter #(.WIDTH(SCNT_W)) u_stall_watchdog (
        .clk   (clk),
        .inc   (run_stall),
        .clr   (rst | ~run_stall),
        .count (scnt)
    );

    // scnt already holds MAX_STALL when the (MAX_STALL+1)th stall cycle is in progress.
    assign timeout_set = run_stall && (scnt >= SCNT_W'(MAX_STALL));

    always_comb begin
        timeout_d = timeout_q | timeout_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            fcnt_q    <= 3'd0;
            dcnt_q    <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_we         = ctrl.pc_we;
    assign pc_sel_br     = ctrl.pc_sel_br;
    assign p0_we         = ctrl.p0_we;
    assign p0_flush      = ctrl.p0_flush;
    assign p1_bubble     = ctrl.p1_bubble;
    assign halted        = !rst && (state_q == ST_HALT);
    assign stall_timeout = !rst && timeout_d;

`ifdef PIPE_PERF_CNT_EN
    logic run_flush;
    assign run_flush = !rst && (state_q == ST_RUN) && !hazard_stall && hazard_flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (run_stall),
        .clr   (rst),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .inc   (run_flush),
        .clr   (rst),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam int FC = 2;
    localparam int DC = 3;
    localparam int MS = 8;
    localparam int CW = 16;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_stall = 1'b0;
    logic hazard_flush = 1'b0;
    logic p1_hlt = 1'b0;
    logic pc_we, pc_sel_br, p0_we, p0_flush, p1_bubble, halted, stall_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES (FC),
        .DRAIN_CYCLES (DC),
        .MAX_STALL    (MS),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_stall  (hazard_stall),
        .hazard_flush  (hazard_flush),
        .p1_hlt        (p1_hlt),
        .pc_we         (pc_we),
        .pc_sel_br     (pc_sel_br),
        .p0_we         (p0_we),
        .p0_flush      (p0_flush),
        .p1_bubble     (p1_bubble),
        .halted        (halted),
        .stall_timeout (stall_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: extra squash cycles still owed, drain cycles still owed, halt flag,
    // length of the current stall run, sticky timeout, event totals.
    int     m_flush_left = 0;
    int     m_drain_left = 0;
    int     m_consec     = 0;
    bit     m_halted     = 1'b0;
    bit     m_to         = 1'b0;
    longint m_scnt       = 0;
    longint m_fcnt       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [4:0] e;
        bit run_cyc, rs, e_to, e_halt;
        run_cyc = !rst && !m_halted && (m_drain_left == 0) && (m_flush_left == 0);
        rs      = run_cyc && hazard_stall;
        e_to    = !rst && (m_to || (rs && (m_consec >= MS)));
        e_halt  = !rst && m_halted;
        // e = {pc_we, pc_sel_br, p0_we, p0_flush, p1_bubble}
        if (rst || m_halted)         e = 5'b00011;
        else if (m_drain_left > 0)   e = 5'b00111;
        else if (m_flush_left > 0)   e = 5'b10110;
        else if (hazard_stall)       e = 5'b00001;
        else if (hazard_flush)       e = 5'b11110;
        else if (p1_hlt)             e = 5'b00110;
        else                         e = 5'b10100;
        chk("pc_we",         64'(pc_we),         64'(e[4]));
        chk("pc_sel_br",     64'(pc_sel_br),     64'(e[3]));
        chk("p0_we",         64'(p0_we),         64'(e[2]));
        chk("p0_flush",      64'(p0_flush),      64'(e[1]));
        chk("p1_bubble",     64'(p1_bubble),     64'(e[0]));
        chk("halted",        64'(halted),        64'(e_halt));
        chk("stall_timeout", 64'(stall_timeout), 64'(e_to));
        chk("stall_cnt",     64'(stall_cnt),     PERF ? 64'(m_scnt) : 64'd0);
        chk("flush_cnt",     64'(flush_cnt),     PERF ? 64'(m_fcnt) : 64'd0);
        if (rst) begin
            m_flush_left = 0; m_drain_left = 0; m_consec = 0;
            m_halted = 1'b0; m_to = 1'b0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (m_halted) begin
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (hazard_stall) begin
                if (m_scnt < CMAX) m_scnt++;
            end else if (hazard_flush) begin
                if (m_fcnt < CMAX) m_fcnt++;
                m_flush_left = FC - 1;
            end else if (p1_hlt) begin
                m_drain_left = DC - 1;
                if (m_drain_left == 0) m_halted = 1'b1;
            end
            m_consec = rs ? ((m_consec < 255) ? m_consec + 1 : 255) : 0;
            m_to     = e_to;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit f, input bit h);
        @(posedge clk);
        #2;
        rst = r; hazard_stall = s; hazard_flush = f; p1_hlt = h;
        @(negedge clk);
        model_step();
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        chk("lit_rst_p0_flush", 64'(p0_flush), 64'd1);
        chk("lit_rst_pc_we", 64'(pc_we), 64'd0);
        cyc(1, 0, 0, 0);

        // Two-cycle load-use stall.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0);
            chk("lit_stall_pc_we", 64'(pc_we), 64'd0);
            chk("lit_stall_bubble", 64'(p1_bubble), 64'd1);
        end
        cyc(0, 0, 0, 0);
        chk("lit_stall_release", 64'(pc_we), 64'd1);
        chk("lit_stall_cnt", 64'(stall_cnt), PERF ? 64'd2 : 64'd0);

        // Taken branch, two squash cycles.
        cyc(0, 0, 1, 0);
        chk("lit_br0_sel", 64'(pc_sel_br), 64'd1);
        chk("lit_br0_flush", 64'(p0_flush), 64'd1);
        cyc(0, 0, 0, 0);
        chk("lit_br1_sel", 64'(pc_sel_br), 64'd0);
        chk("lit_br1_flush", 64'(p0_flush), 64'd1);
        cyc(0, 0, 0, 0);
        chk("lit_br2_flush", 64'(p0_flush), 64'd0);
        chk("lit_flush_cnt", 64'(flush_cnt), PERF ? 64'd1 : 64'd0);

        // Branch held behind a stall, redirect next cycle.
        cyc(0, 1, 1, 0);
        chk("lit_sf_sel", 64'(pc_sel_br), 64'd0);
        cyc(0, 0, 1, 0);
        chk("lit_sf_redirect", 64'(pc_sel_br), 64'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Watchdog: timeout rises on the 9th consecutive stall cycle and sticks.
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 0, 0);
            chk("lit_wd", 64'(stall_timeout), (i == 9) ? 64'd1 : 64'd0);
        end
        cyc(0, 0, 0, 0);
        chk("lit_wd_sticky", 64'(stall_timeout), 64'd1);

        // Reset in the middle of a flush sequence.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("lit_rstf_pc_we", 64'(pc_we), 64'd0);
        chk("lit_rstf_bubble", 64'(p1_bubble), 64'd1);
        chk("lit_rstf_to", 64'(stall_timeout), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_rstf_run", 64'(p0_flush), 64'd0);
        chk("lit_rstf_cnt", 64'(flush_cnt), 64'd0);

        // HLT drain then halt, immune to hazards until reset.
        cyc(0, 0, 0, 1);
        chk("lit_hlt0", 64'(halted), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_hlt1", 64'(halted), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_hlt2", 64'(halted), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_hlt3", 64'(halted), 64'd1);
        cyc(0, 1, 0, 0);
        chk("lit_hlt_stall", 64'(halted), 64'd1);
        cyc(0, 0, 1, 0);
        chk("lit_hlt_flush_sel", 64'(pc_sel_br), 64'd0);
        cyc(1, 0, 0, 0);
        chk("lit_hlt_rst", 64'(halted), 64'd0);
        cyc(0, 0, 0, 0);
        chk("lit_hlt_after_rst", 64'(pc_we), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 29) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
